key_debounce_fsm: RTL and testbench



---
 rtl/key_debounce_fsm.sv | 121 ++++++++++++
 tb/tb_key_debounce_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_fsm.sv
// Debounce and event stage for one mechanical key: two-flop synchroniser,
// stable-count qualification of each edge, registered press/release/long pulses.
module key_debounce_fsm #(
  parameter int DEB_CYCLES  = 15,
  parameter int LONG_CYCLES = 100,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic             s1, key_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] long_cnt, long_nxt;
  logic             long_done, done_nxt;
  logic             level_nxt, press_nxt, release_nxt, long_pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      key_s <= 1'b0;
    end else begin
      s1    <= key_in;
      key_s <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      long_cnt    <= '0;
      long_done   <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      long_cnt    <= long_nxt;
      long_done   <= done_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    deb_nxt        = deb_cnt;
    long_nxt       = long_cnt;
    done_nxt       = long_done;
    level_nxt      = key_level;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_CHK;
          deb_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          long_nxt  = '0;
          done_nxt  = 1'b0;
        end else begin
          deb_nxt = deb_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          if (long_cnt < LONG_SAT) long_nxt = long_cnt + CNT_W'(1);
          // long_done keeps a saturated counter from re-arming the pulse
          if (long_cnt == LONG_LAST && !long_done) begin
            long_pulse_nxt = 1'b1;
            done_nxt       = 1'b1;
          end
        end else begin
          state_nxt = RELEASE_CHK;
          deb_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        // a bounce back high resumes HELD with long_cnt untouched
        if (key_s) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Scoreboard bench for key_debounce_fsm (DEB=4, LONG=20): stimulus queues
// expected pulse/level observations, a negedge monitor pops and compares.
module tb_key_debounce_fsm;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = DEB + 3;

  // observation vector is {key_level, key_long, key_release, key_press}
  localparam logic [3:0] EV_PRESS = 4'b1001;
  localparam logic [3:0] EV_LONG  = 4'b1100;
  localparam logic [3:0] EV_REL   = 4'b0010;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b0;
  logic key_level, key_press, key_release, key_long;
  int   cyc = 0;
  bit   done = 1'b0;

  exp_t evq[$];
  exp_t lvq[$];
  int   errors = 0;
  int   checks = 0;

  key_debounce_fsm #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ev(input string name, input int at, input logic [3:0] v);
    exp_t e;
    e.cyc = at; e.val = v; e.name = name;
    evq.push_back(e);
  endtask

  task automatic exp_lv(input string name, input logic [3:0] v);
    exp_t e;
    e.cyc = cyc; e.val = v; e.name = name;
    lvq.push_back(e);
  endtask

  // monitor: all comparisons live here
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t e;
    obs = {key_level, key_long, key_release, key_press};
    if (|obs[2:0]) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got %b at cycle %0d, expected none", obs, cyc);
      end else begin
        e = evq.pop_front();
        if (e.cyc != cyc || e.val !== obs) begin
          errors++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                   e.name, obs, cyc, e.val, e.cyc);
        end
      end
    end else if (evq.size() != 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no pulse seen, expected %b at cycle %0d", e.name, e.val, e.cyc);
    end
    if (lvq.size() != 0 && lvq[0].cyc == cyc) begin
      e = lvq.pop_front();
      checks++;
      if (e.val !== obs) begin
        errors++;
        $display("FAIL %s: got %b at cycle %0d, expected %b", e.name, obs, cyc, e.val);
      end
    end
    if (done || cyc > 3000) begin
      checks++;
      if (!done || evq.size() != 0 || lvq.size() != 0) begin
        errors++;
        $display("FAIL end_of_run: done=%0d pending_pulses=%0d pending_levels=%0d, expected 1/0/0",
                 done, evq.size(), lvq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    int t;
    // reset state
    step(3);
    exp_lv("reset_outputs", 4'b0000);
    step(1);
    rst = 1'b0;
    step(4);

    // clean press, long press once, clean release
    key_in = 1'b1; t = cyc;
    exp_ev("clean_press", t + LAT, EV_PRESS);
    exp_ev("clean_long", t + LAT + LONG, EV_LONG);
    step(12);
    exp_lv("clean_level_high", 4'b1000);
    step(38);
    key_in = 1'b0; t = cyc;
    exp_ev("clean_release", t + LAT, EV_REL);
    step(15);
    exp_lv("clean_level_low", 4'b0000);

    // press bounce: 1,0,1,0 at 2-cycle intervals, then stable high
    key_in = 1'b1; step(2);
    key_in = 1'b0; step(2);
    key_in = 1'b1; step(2);
    key_in = 1'b0; step(2);
    key_in = 1'b1; t = cyc;
    exp_ev("bounce_press", t + LAT, EV_PRESS);
    exp_ev("bounce_long", t + LAT + LONG, EV_LONG);
    step(35);
    key_in = 1'b0; t = cyc;
    exp_ev("bounce_release", t + LAT, EV_REL);
    step(15);

    // short pulse: never accepted
    key_in = 1'b1; step(3);
    key_in = 1'b0; step(15);
    exp_lv("short_level_low", 4'b0000);

    // release bounce: 2-cycle dip from HELD must not release
    key_in = 1'b1; t = cyc;
    exp_ev("relb_press", t + LAT, EV_PRESS);
    exp_ev("relb_long", t + LAT + LONG, EV_LONG);
    step(30);
    key_in = 1'b0; step(2);
    key_in = 1'b1; step(8);
    exp_lv("relb_level_kept", 4'b1000);
    key_in = 1'b0; t = cyc;
    exp_ev("relb_release", t + LAT, EV_REL);
    step(15);

    // long press crossing a glitch: 3 uncounted cycles push key_long out
    key_in = 1'b1; t = cyc;
    exp_ev("xlong_press", t + LAT, EV_PRESS);
    exp_ev("xlong_long", t + 30, EV_LONG);
    step(17);
    key_in = 1'b0; step(2);
    key_in = 1'b1; step(30);
    key_in = 1'b0; t = cyc;
    exp_ev("xlong_release", t + LAT, EV_REL);
    step(15);

    // reset mid-HELD with key still pressed
    key_in = 1'b1; t = cyc;
    exp_ev("rst_first_press", t + LAT, EV_PRESS);
    step(12);
    exp_lv("rst_pre_level", 4'b1000);
    rst = 1'b1; step(1);
    exp_lv("rst_mid_held", 4'b0000);
    rst = 1'b0; t = cyc;
    exp_ev("rst_fresh_press", t + LAT, EV_PRESS);
    exp_ev("rst_fresh_long", t + LAT + LONG, EV_LONG);
    step(40);
    key_in = 1'b0; t = cyc;
    exp_ev("rst_release", t + LAT, EV_REL);
    step(15);
    exp_lv("final_level_low", 4'b0000);
    step(2);
    done = 1'b1;
  end

endmodule
